// File: rtl/cv32e40px_core_v_xif_pkg.sv
// Shared XIF issue-tracker types: table entry layout, default sizing and register mask helper.
// CV32E40PX_X_DUALREAD_EN adds a dualwrite flag to each entry for rd/rd|1 pair tracking.
package cv32e40px_core_v_xif_pkg;

  localparam int unsigned X_ID_WIDTH        = 4;
  localparam int unsigned X_MAX_OUTSTANDING = 4;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       writeback;
`ifdef CV32E40PX_X_DUALREAD_EN
    logic       dualwrite;
`endif
  } x_entry_t;

  // One-hot mask of a register (plus its odd pair partner); x0 is never tracked.
  function automatic logic [31:0] reg_mask(input logic [4:0] r, input logic pair);
    logic [31:0] m;
    m = 32'd1 << r;
    if (pair) m[{r[4:1], 1'b1}] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/cv32e40px_x_pend_cnt.sv
// Array of 32 saturating pending-writer counters: one increment mask and two decrement masks
// (result retire, commit kill) per cycle, with combinational nonzero/one/saturated lookups.
module cv32e40px_x_pend_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] inc_i,
  input  logic [31:0] dec_res_i,
  input  logic [31:0] dec_kill_i,
  output logic [31:0] nonzero_o,
  output logic [31:0] one_o,
  output logic [31:0] sat_o
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [31:0]      underflow;

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c, input logic inc,
                                                input logic [1:0] dec);
    int net;
    net = int'(c) + int'(inc) - int'(dec);
    if (net < 0) return '0;
    else if (net > CNT_MAX) return '1;
    else return CNT_W'(net);
  endfunction

  always_comb begin
    underflow = '0;
    for (int i = 0; i < 32; i++) begin
      cnt_d[i]     = sat_step(cnt_q[i], inc_i[i], {1'b0, dec_res_i[i]} + {1'b0, dec_kill_i[i]});
      underflow[i] = (cnt_q[i] == '0) & (dec_res_i[i] | dec_kill_i[i]) & ~inc_i[i];
      nonzero_o[i] = |cnt_q[i];
      one_o[i]     = (cnt_q[i] == CNT_W'(1));
      sat_o[i]     = &cnt_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifndef SYNTHESIS
  // A decrement hitting an idle counter must leave it at zero.
  hold_zero_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (|underflow) |=> ((nonzero_o & $past(underflow)) == '0));
`endif

endmodule

// File: rtl/cv32e40px_x_issue_tracker.sv
// Multi-outstanding CORE-V-XIF dispatcher: ID table, per-register pending writers, commit-kill,
// result backpressure and memory-transaction counting. CV32E40PX_X_DUALREAD_EN enables pair tracking.
module cv32e40px_x_issue_tracker
  import cv32e40px_core_v_xif_pkg::*;
#(
  parameter int unsigned ID_WIDTH        = X_ID_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = X_MAX_OUTSTANDING,
  parameter int unsigned PEND_CNT_W      = 2,
  parameter int unsigned MEM_CNT_W       = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_req_i,
  input  logic [4:0]          issue_rd_i,
  input  logic [2:0][4:0]     issue_rs_addr_i,
  input  logic [2:0]          issue_regs_used_i,
  input  logic                id_ready_i,
  input  logic                kill_i,
  output logic                x_issue_valid_o,
  input  logic                x_issue_ready_i,
  output logic [ID_WIDTH-1:0] x_issue_req_id_o,
  input  logic                x_issue_resp_accept_i,
  input  logic                x_issue_resp_writeback_i,
  input  logic                x_issue_resp_dualread_i,
  input  logic                x_issue_resp_loadstore_i,
  output logic                x_commit_valid_o,
  output logic [ID_WIDTH-1:0] x_commit_id_o,
  output logic                x_commit_kill_o,
  input  logic                x_result_valid_i,
  output logic                x_result_ready_o,
  input  logic [ID_WIDTH-1:0] x_result_id_i,
  input  logic [4:0]          x_result_rd_i,
  input  logic                x_result_we_i,
  input  logic                wb_free_i,
  input  logic                x_mem_valid_i,
  output logic                x_mem_ready_o,
  input  logic                ex_ready_i,
  input  logic                data_req_dec_i,
  output logic                stall_o,
  output logic                illegal_o,
  output logic [ID_WIDTH:0]   outstanding_o
);

  localparam int unsigned         NENT    = 2 ** ID_WIDTH;
  localparam logic [ID_WIDTH:0]   MAX_OUT = (ID_WIDTH+1)'(MAX_OUTSTANDING);

  x_entry_t             table_q [NENT];
  x_entry_t             table_d [NENT];
  logic [ID_WIDTH-1:0]  id_q, id_d, commit_id_q;
  logic                 commit_valid_q, offloaded_q, offloaded_d;
  logic [ID_WIDTH:0]    outst_q, outst_d;
  logic [MEM_CNT_W-1:0] mem_cnt_q, mem_cnt_d;

  x_entry_t    res_entry, kill_entry;
  logic        res_retire, kill_free, issue_hs, issue_acc;
  logic        table_full, dep, rd_sat, mem_sat, mem_inc, mem_dec;
  logic        pair_rd, res_pair, kill_pair;
  logic [31:0] rs_mask, res_mask, kill_mask, inc_mask;
  logic [31:0] pend_nz, pend_one, pend_sat;
  logic        unused_res_rd;

  assign unused_res_rd = ^x_result_rd_i;
  assign res_entry     = table_q[x_result_id_i];
  assign kill_entry    = table_q[commit_id_q];

`ifdef CV32E40PX_X_DUALREAD_EN
  assign pair_rd   = x_issue_resp_dualread_i;
  assign res_pair  = res_entry.dualwrite;
  assign kill_pair = kill_entry.dualwrite;
`else
  logic unused_dualread;
  assign unused_dualread = x_issue_resp_dualread_i;
  assign pair_rd   = 1'b0;
  assign res_pair  = 1'b0;
  assign kill_pair = 1'b0;
`endif

  // A result that races a kill of the same ID is dropped so the entry is freed only once.
  always_comb begin
    kill_free  = commit_valid_q & kill_i & kill_entry.valid;
    res_retire = x_result_valid_i & wb_free_i & res_entry.valid &
                 ~(kill_free & (x_result_id_i == commit_id_q));
    res_mask   = (res_retire & res_entry.writeback & x_result_we_i) ?
                 reg_mask(res_entry.rd, res_pair) : '0;
    kill_mask  = (kill_free & kill_entry.writeback) ? reg_mask(kill_entry.rd, kill_pair) : '0;
    rs_mask    = '0;
    for (int i = 0; i < 3; i++) begin
      if (issue_regs_used_i[i]) rs_mask |= reg_mask(issue_rs_addr_i[i], pair_rd);
    end
    table_full = table_q[id_q].valid | (outst_q == MAX_OUT);
    dep        = |(rs_mask & pend_nz & ~(res_mask & pend_one));
    rd_sat     = |(reg_mask(issue_rd_i, pair_rd) & pend_sat);
    mem_sat    = (&mem_cnt_q) & x_issue_resp_loadstore_i;
    x_issue_valid_o = issue_req_i & ~offloaded_q & ~kill_i & ~table_full & ~dep & ~rd_sat &
                      ~mem_sat;
    issue_hs   = x_issue_valid_o & x_issue_ready_i;
    issue_acc  = issue_hs & x_issue_resp_accept_i;
    inc_mask   = (issue_acc & x_issue_resp_writeback_i) ? reg_mask(issue_rd_i, pair_rd) : '0;
  end

  always_comb begin
    table_d = table_q;
    if (res_retire) table_d[x_result_id_i].valid = 1'b0;
    if (kill_free)  table_d[commit_id_q].valid = 1'b0;
    if (issue_acc) begin
      table_d[id_q].valid     = 1'b1;
      table_d[id_q].rd        = issue_rd_i;
      table_d[id_q].writeback = x_issue_resp_writeback_i;
`ifdef CV32E40PX_X_DUALREAD_EN
      table_d[id_q].dualwrite = x_issue_resp_dualread_i;
`endif
    end
    id_d        = issue_acc ? id_q + 1'b1 : id_q;
    // ID advancing always retires the offloaded marker, even in the issuing cycle.
    offloaded_d = id_ready_i ? 1'b0 : (offloaded_q | issue_acc);
    outst_d     = outst_q + (ID_WIDTH+1)'(issue_acc) - (ID_WIDTH+1)'(res_retire) -
                  (ID_WIDTH+1)'(kill_free);
    mem_inc     = issue_acc & x_issue_resp_loadstore_i;
    mem_dec     = x_mem_valid_i & ex_ready_i & (mem_cnt_q != '0);
    mem_cnt_d   = mem_cnt_q;
    if (mem_inc & ~mem_dec)      mem_cnt_d = mem_cnt_q + 1'b1;
    else if (mem_dec & ~mem_inc) mem_cnt_d = mem_cnt_q - 1'b1;
  end

  cv32e40px_x_pend_cnt #(
    .CNT_W (PEND_CNT_W)
  ) u_pend_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .inc_i      (inc_mask),
    .dec_res_i  (res_mask),
    .dec_kill_i (kill_mask),
    .nonzero_o  (pend_nz),
    .one_o      (pend_one),
    .sat_o      (pend_sat)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NENT; i++) table_q[i] <= '0;
      id_q           <= '0;
      commit_id_q    <= '0;
      commit_valid_q <= 1'b0;
      offloaded_q    <= 1'b0;
      outst_q        <= '0;
      mem_cnt_q      <= '0;
    end else begin
      table_q        <= table_d;
      id_q           <= id_d;
      commit_id_q    <= id_q;
      commit_valid_q <= issue_acc;
      offloaded_q    <= offloaded_d;
      outst_q        <= outst_d;
      mem_cnt_q      <= mem_cnt_d;
    end
  end

  assign x_issue_req_id_o = id_q;
  assign x_commit_valid_o = commit_valid_q;
  assign x_commit_id_o    = commit_id_q;
  assign x_commit_kill_o  = commit_valid_q & kill_i;
  assign x_result_ready_o = wb_free_i;
  assign x_mem_ready_o    = ex_ready_i;
  assign illegal_o        = issue_hs & ~x_issue_resp_accept_i;
  assign stall_o          = (issue_req_i & ~offloaded_q & ~issue_acc) |
                            (data_req_dec_i & (mem_cnt_q != '0));
  assign outstanding_o    = outst_q;

endmodule

// File: tb/tb_cv32e40px_x_issue_tracker.sv
// Directed bench for cv32e40px_x_issue_tracker with hand-computed expectations.
module tb_cv32e40px_x_issue_tracker;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            issue_req_i;
  logic [4:0]      issue_rd_i;
  logic [2:0][4:0] issue_rs_addr_i;
  logic [2:0]      issue_regs_used_i;
  logic            id_ready_i, kill_i;
  logic            x_issue_valid_o, x_issue_ready_i;
  logic [3:0]      x_issue_req_id_o;
  logic            x_issue_resp_accept_i, x_issue_resp_writeback_i;
  logic            x_issue_resp_dualread_i, x_issue_resp_loadstore_i;
  logic            x_commit_valid_o, x_commit_kill_o;
  logic [3:0]      x_commit_id_o;
  logic            x_result_valid_i, x_result_ready_o, x_result_we_i;
  logic [3:0]      x_result_id_i;
  logic [4:0]      x_result_rd_i;
  logic            wb_free_i, x_mem_valid_i, x_mem_ready_o, ex_ready_i, data_req_dec_i;
  logic            stall_o, illegal_o;
  logic [4:0]      outstanding_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  cv32e40px_x_issue_tracker dut (
    .clk_i                    (clk_i),
    .rst_ni                   (rst_ni),
    .issue_req_i              (issue_req_i),
    .issue_rd_i               (issue_rd_i),
    .issue_rs_addr_i          (issue_rs_addr_i),
    .issue_regs_used_i        (issue_regs_used_i),
    .id_ready_i               (id_ready_i),
    .kill_i                   (kill_i),
    .x_issue_valid_o          (x_issue_valid_o),
    .x_issue_ready_i          (x_issue_ready_i),
    .x_issue_req_id_o         (x_issue_req_id_o),
    .x_issue_resp_accept_i    (x_issue_resp_accept_i),
    .x_issue_resp_writeback_i (x_issue_resp_writeback_i),
    .x_issue_resp_dualread_i  (x_issue_resp_dualread_i),
    .x_issue_resp_loadstore_i (x_issue_resp_loadstore_i),
    .x_commit_valid_o         (x_commit_valid_o),
    .x_commit_id_o            (x_commit_id_o),
    .x_commit_kill_o          (x_commit_kill_o),
    .x_result_valid_i         (x_result_valid_i),
    .x_result_ready_o         (x_result_ready_o),
    .x_result_id_i            (x_result_id_i),
    .x_result_rd_i            (x_result_rd_i),
    .x_result_we_i            (x_result_we_i),
    .wb_free_i                (wb_free_i),
    .x_mem_valid_i            (x_mem_valid_i),
    .x_mem_ready_o            (x_mem_ready_o),
    .ex_ready_i               (ex_ready_i),
    .data_req_dec_i           (data_req_dec_i),
    .stall_o                  (stall_o),
    .illegal_o                (illegal_o),
    .outstanding_o            (outstanding_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_issue(input logic [4:0] rd, input logic [2:0] used, input logic [4:0] rs0);
    issue_req_i        = 1'b1;
    issue_rd_i         = rd;
    issue_regs_used_i  = used;
    issue_rs_addr_i[0] = rs0;
  endtask

  task automatic result(input logic [3:0] id, input logic we);
    x_result_valid_i = 1'b1;
    x_result_id_i    = id;
    x_result_we_i    = we;
    wb_free_i        = 1'b1;
  endtask

  task automatic result_off();
    x_result_valid_i = 1'b0;
    wb_free_i        = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] retire_ids [4];
    rst_ni = 1'b0;
    issue_req_i = 1'b0; issue_rd_i = '0; issue_rs_addr_i = '0; issue_regs_used_i = '0;
    id_ready_i = 1'b0; kill_i = 1'b0; x_issue_ready_i = 1'b0;
    x_issue_resp_accept_i = 1'b0; x_issue_resp_writeback_i = 1'b0;
    x_issue_resp_dualread_i = 1'b0; x_issue_resp_loadstore_i = 1'b0;
    x_result_valid_i = 1'b0; x_result_id_i = '0; x_result_rd_i = '0; x_result_we_i = 1'b0;
    wb_free_i = 1'b0; x_mem_valid_i = 1'b0; ex_ready_i = 1'b0; data_req_dec_i = 1'b0;
    #1;
    chk("rst_issue_valid", 32'(x_issue_valid_o), 32'd0);
    chk("rst_commit_valid", 32'(x_commit_valid_o), 32'd0);
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("rst_req_id", 32'(x_issue_req_id_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_illegal", 32'(illegal_o), 32'd0);
    chk("rst_result_ready", 32'(x_result_ready_o), 32'd0);
    chk("rst_mem_ready", 32'(x_mem_ready_o), 32'd0);
    wb_free_i = 1'b1;
    #1 chk("result_ready_follows", 32'(x_result_ready_o), 32'd1);
    wb_free_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    x_issue_ready_i = 1'b1; x_issue_resp_accept_i = 1'b1; x_issue_resp_writeback_i = 1'b1;

    // Four back-to-back writeback offloads, then a fifth that must wait for a free slot.
    for (int k = 0; k < 4; k++) begin
      set_issue(5'(5 + k), 3'b000, 5'd0);
      id_ready_i = 1'b1;
      #1;
      chk("fill_valid", 32'(x_issue_valid_o), 32'd1);
      chk("fill_id", 32'(x_issue_req_id_o), 32'(k));
      chk("fill_stall", 32'(stall_o), 32'd0);
      if (k > 0) chk("fill_commit_id", 32'(x_commit_id_o), 32'(k - 1));
      tick();
    end
    set_issue(5'd9, 3'b000, 5'd0);
    id_ready_i = 1'b0;
    #1;
    chk("full_valid", 32'(x_issue_valid_o), 32'd0);
    chk("full_stall", 32'(stall_o), 32'd1);
    chk("full_outstanding", 32'(outstanding_o), 32'd4);
    chk("full_commit", 32'({x_commit_valid_o, x_commit_id_o}), 32'h13);
    tick();
    result(4'd1, 1'b1);
    #1;
    chk("retire_same_cycle_valid", 32'(x_issue_valid_o), 32'd0);
    chk("retire_ready", 32'(x_result_ready_o), 32'd1);
    tick();
    result_off();
    #1;
    chk("resume_outstanding", 32'(outstanding_o), 32'd3);
    chk("resume_valid", 32'(x_issue_valid_o), 32'd1);
    chk("resume_id", 32'(x_issue_req_id_o), 32'd4);
    id_ready_i = 1'b1;
    tick();
    issue_req_i = 1'b0; id_ready_i = 1'b0;
    #1 chk("resume_outstanding4", 32'(outstanding_o), 32'd4);
    retire_ids = '{4'd0, 4'd2, 4'd3, 4'd4};
    for (int k = 0; k < 4; k++) begin
      result(retire_ids[k], 1'b1);
      tick();
    end
    result_off();
    #1 chk("drain_outstanding", 32'(outstanding_o), 32'd0);

    // Two writers of x10, consumer waits for the second retire (bypass on pend==1).
    for (int k = 0; k < 2; k++) begin
      set_issue(5'd10, 3'b000, 5'd0);
      id_ready_i = 1'b1;
      tick();
    end
    set_issue(5'd11, 3'b001, 5'd10);
    id_ready_i = 1'b0;
    #1;
    chk("dep_p2_valid", 32'(x_issue_valid_o), 32'd0);
    chk("dep_p2_stall", 32'(stall_o), 32'd1);
    result(4'd5, 1'b1);
    #1 chk("dep_p2_res_valid", 32'(x_issue_valid_o), 32'd0);
    tick();
    result(4'd6, 1'b1);
    #1;
    chk("dep_p1_bypass_valid", 32'(x_issue_valid_o), 32'd1);
    chk("dep_p1_bypass_id", 32'(x_issue_req_id_o), 32'd7);
    x_issue_resp_writeback_i = 1'b0;
    id_ready_i = 1'b1;
    tick();
    result_off();
    issue_req_i = 1'b0; issue_regs_used_i = '0; id_ready_i = 1'b0;
    x_issue_resp_writeback_i = 1'b1;
    #1 chk("dep_outstanding", 32'(outstanding_o), 32'd1);
    result(4'd7, 1'b0);
    tick();
    result_off();
    #1 chk("dep_drain", 32'(outstanding_o), 32'd0);

    // Rejected offload.
    set_issue(5'd12, 3'b000, 5'd0);
    x_issue_resp_accept_i = 1'b0;
    #1;
    chk("rej_illegal", 32'(illegal_o), 32'd1);
    chk("rej_id", 32'(x_issue_req_id_o), 32'd8);
    tick();
    issue_req_i = 1'b0;
    x_issue_resp_accept_i = 1'b1;
    #1;
    chk("rej_illegal_drop", 32'(illegal_o), 32'd0);
    chk("rej_id_kept", 32'(x_issue_req_id_o), 32'd8);
    chk("rej_outstanding", 32'(outstanding_o), 32'd0);
    chk("rej_no_commit", 32'(x_commit_valid_o), 32'd0);

    // Kill in the commit cycle, then a late result for the killed ID.
    set_issue(5'd10, 3'b000, 5'd0);
    id_ready_i = 1'b1;
    #1 chk("kill_issue_id", 32'(x_issue_req_id_o), 32'd8);
    tick();
    issue_req_i = 1'b0; id_ready_i = 1'b0; kill_i = 1'b1;
    #1 chk("kill_commit", 32'({x_commit_valid_o, x_commit_kill_o, x_commit_id_o}), 32'h38);
    tick();
    kill_i = 1'b0;
    #1;
    chk("kill_outstanding", 32'(outstanding_o), 32'd0);
    chk("kill_pulse_end", 32'(x_commit_kill_o), 32'd0);
    set_issue(5'd11, 3'b001, 5'd10);
    x_issue_ready_i = 1'b0;
    #1 chk("kill_pend_reverted", 32'(x_issue_valid_o), 32'd1);
    x_issue_ready_i = 1'b1;
    set_issue(5'd10, 3'b000, 5'd0);
    id_ready_i = 1'b1;
    #1 chk("kill_next_id", 32'(x_issue_req_id_o), 32'd9);
    tick();
    id_ready_i = 1'b0;
    set_issue(5'd11, 3'b001, 5'd10);
    x_issue_ready_i = 1'b0;
    result(4'd8, 1'b1);
    #1 chk("late_res_no_bypass", 32'(x_issue_valid_o), 32'd0);
    tick();
    result_off();
    #1;
    chk("late_res_x10_kept", 32'(x_issue_valid_o), 32'd0);
    chk("late_res_outstanding", 32'(outstanding_o), 32'd1);
    result(4'd9, 1'b1);
    #1 chk("res9_bypass", 32'(x_issue_valid_o), 32'd1);
    tick();
    result_off();
    issue_req_i = 1'b0; issue_regs_used_i = '0; x_issue_ready_i = 1'b1;
    #1 chk("kill_drain", 32'(outstanding_o), 32'd0);

    // Result backpressure.
    set_issue(5'd12, 3'b000, 5'd0);
    id_ready_i = 1'b1;
    tick();
    issue_req_i = 1'b0; id_ready_i = 1'b0;
    result(4'd10, 1'b1);
    wb_free_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(x_result_ready_o), 32'd0);
      chk("bp_frozen", 32'(outstanding_o), 32'd1);
      tick();
    end
    wb_free_i = 1'b1;
    #1 chk("bp_ready_rise", 32'(x_result_ready_o), 32'd1);
    tick();
    result_off();
    #1 chk("bp_retired", 32'(outstanding_o), 32'd0);

    // Loadstore offload holds ID data requests until the memory handshake.
    set_issue(5'd13, 3'b000, 5'd0);
    x_issue_resp_writeback_i = 1'b0; x_issue_resp_loadstore_i = 1'b1; id_ready_i = 1'b1;
    #1 chk("ls_issue_id", 32'(x_issue_req_id_o), 32'd11);
    tick();
    issue_req_i = 1'b0; id_ready_i = 1'b0;
    x_issue_resp_writeback_i = 1'b1; x_issue_resp_loadstore_i = 1'b0;
    data_req_dec_i = 1'b1;
    #1 chk("ls_stall0", 32'(stall_o), 32'd1);
    tick();
    chk("ls_stall1", 32'(stall_o), 32'd1);
    x_mem_valid_i = 1'b1; ex_ready_i = 1'b1;
    #1;
    chk("ls_mem_ready", 32'(x_mem_ready_o), 32'd1);
    chk("ls_stall_hs", 32'(stall_o), 32'd1);
    tick();
    x_mem_valid_i = 1'b0; ex_ready_i = 1'b0;
    #1 chk("ls_stall_clear", 32'(stall_o), 32'd0);
    data_req_dec_i = 1'b0;
    result(4'd11, 1'b0);
    tick();
    result_off();
    #1 chk("ls_drain", 32'(outstanding_o), 32'd0);

    // Reset mid-operation, then a late result for a discarded entry.
    set_issue(5'd14, 3'b000, 5'd0);
    id_ready_i = 1'b1;
    #1 chk("mid_rst_issue_id", 32'(x_issue_req_id_o), 32'd12);
    tick();
    issue_req_i = 1'b0; id_ready_i = 1'b0;
    #1 chk("mid_rst_pre", 32'(outstanding_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("mid_rst_commit", 32'(x_commit_valid_o), 32'd0);
    chk("mid_rst_id", 32'(x_issue_req_id_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    result(4'd12, 1'b1);
    tick();
    result_off();
    #1 chk("post_rst_late_res", 32'(outstanding_o), 32'd0);
    set_issue(5'd15, 3'b001, 5'd14);
    #1 chk("post_rst_pend_clear", 32'({x_issue_valid_o, x_issue_req_id_o}), 32'h10);
    issue_req_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
